// File: rtl/shift_stage_pkg.sv
// Shared types and constants for the RV32I shift execute stage.
package shift_stage_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SRX = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage_barrel_shifter.sv
// Logarithmic barrel shifter; left shifts reuse the right-shift ladder on bit-reversed data.
module barrel_shifter
    import shift_stage_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amt,
    input  logic              i_right,
    input  logic              i_arith,
    output logic [DATA_W-1:0] o_data
);

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W; k++) begin
            r[k] = x[DATA_W-1-k];
        end
        return r;
    endfunction

    logic [DATA_W-1:0]      w_in;
    logic signed [DATA_W:0] w_acc;

    // Extra top bit carries the fill value so >>> replicates it at every stage.
    always_comb begin
        w_in  = i_right ? i_data : bit_rev(i_data);
        w_acc = {i_right & i_arith & i_data[DATA_W-1], w_in};
        for (int s = 0; s < AMT_W; s++) begin
            if (i_amt[s]) begin
                w_acc = w_acc >>> (1 << s);
            end
        end
        o_data = i_right ? w_acc[DATA_W-1:0] : bit_rev(w_acc[DATA_W-1:0]);
    end

endmodule

// File: rtl/shift_stage.sv
// RV32I shift execute stage: decode + barrel shift, registered into a 2-entry skid buffer.
module shift_stage
    import shift_stage_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic             i_funct7_5,
    input  logic             i_use_imm,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [4:0]       i_imm,
    input  logic [4:0]       i_rd,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [4:0]       o_rd,
    output logic             o_illegal
);

    logic [SHAMT_W-1:0] w_amt;
    logic               w_is_sll;
    logic               w_is_srx;
    logic               w_illegal;
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_result;
    logic               w_accept;
    logic               w_drain;
    logic               w_unused_rs2;

    // Stage p0: decode and combinational shift
    assign w_amt        = i_use_imm ? i_imm : i_rs2[SHAMT_W-1:0];
    assign w_unused_rs2 = ^i_rs2[XLEN-1:SHAMT_W];
    assign w_is_sll     = (i_funct3 == FUNCT3_SLL) && !i_funct7_5;
    assign w_is_srx     = (i_funct3 == FUNCT3_SRX);
    assign w_illegal    = !(w_is_sll || w_is_srx);

    barrel_shifter #(
        .DATA_W (XLEN),
        .AMT_W  (SHAMT_W)
    ) u_shifter (
        .i_data  (i_rs1),
        .i_amt   (w_amt),
        .i_right (w_is_srx),
        .i_arith (i_funct7_5),
        .o_data  (w_shifted)
    );

    assign w_result = w_illegal ? '0 : w_shifted;

    state_t          r_state;
    logic            r_ready;
    logic            r_valid;
    logic [XLEN-1:0] r_head_result;
    logic [4:0]      r_head_rd;
    logic            r_head_ill;
    logic [XLEN-1:0] r_skid_result;
    logic [4:0]      r_skid_rd;
    logic            r_skid_ill;

    assign w_accept = i_valid && r_ready;
    assign w_drain  = r_valid && i_ready;

    // Stage p1: skid FSM; ready/valid are registered from the next state only
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= EMPTY;
            r_ready       <= 1'b0;
            r_valid       <= 1'b0;
            r_head_result <= '0;
            r_head_rd     <= '0;
            r_head_ill    <= 1'b0;
            r_skid_result <= '0;
            r_skid_rd     <= '0;
            r_skid_ill    <= 1'b0;
        end else if (i_flush) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_head_result <= w_result;
                        r_head_rd     <= i_rd;
                        r_head_ill    <= w_illegal;
                        r_state       <= ONE;
                        r_valid       <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        r_head_result <= w_result;
                        r_head_rd     <= i_rd;
                        r_head_ill    <= w_illegal;
                    end else if (w_accept) begin
                        r_skid_result <= w_result;
                        r_skid_rd     <= i_rd;
                        r_skid_ill    <= w_illegal;
                        r_state       <= TWO;
                        r_ready       <= 1'b0;
                    end else if (w_drain) begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_drain) begin
                        r_head_result <= r_skid_result;
                        r_head_rd     <= r_skid_rd;
                        r_head_ill    <= r_skid_ill;
                        r_state       <= ONE;
                        r_ready       <= 1'b1;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready   = r_ready;
    assign o_valid   = r_valid;
    assign o_result  = r_head_result;
    assign o_rd      = r_head_rd;
    assign o_illegal = r_head_ill;

endmodule

// File: tb/tb_shift_stage.sv
// Randomized and directed bench for shift_stage against a queue-based reference model.
module tb_shift_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_funct3;
    logic        i_funct7_5;
    logic        i_use_imm;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [4:0]  i_imm;
    logic [4:0]  i_rd;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_rd;
    logic        o_illegal;

    always #5 clk = ~clk;

    shift_stage dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_funct3   (i_funct3),
        .i_funct7_5 (i_funct7_5),
        .i_use_imm  (i_use_imm),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .i_imm      (i_imm),
        .i_rd       (i_rd),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_rd       (o_rd),
        .o_illegal  (o_illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } op_t;

    op_t q[$];
    bit  rdy_en;
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic op_t ref_op(input logic [2:0] f3, input logic f7, input logic [4:0] amt,
                                   input logic [31:0] rs1, input logic [4:0] rd);
        op_t o;
        logic signed [31:0] s;
        s     = rs1;
        o.rd  = rd;
        o.ill = 1'b0;
        o.res = 32'h0;
        if (f3 == 3'b001 && !f7) o.res = rs1 << amt;
        else if (f3 == 3'b101 && f7) o.res = s >>> amt;
        else if (f3 == 3'b101) o.res = rs1 >> amt;
        else o.ill = 1'b1;
        return o;
    endfunction

    task automatic check_outputs();
        check("o_ready", 32'(o_ready), 32'(rdy_en && q.size() < 2));
        check("o_valid", 32'(o_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("o_result", o_result, q[0].res);
            check("o_rd", 32'(o_rd), 32'(q[0].rd));
            check("o_illegal", 32'(o_illegal), 32'(q[0].ill));
        end
    endtask

    // Called at a falling edge; drives one cycle, advances the model, checks at the next falling edge.
    task automatic cycle(input logic v, input logic [2:0] f3, input logic f7, input logic ui,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] imm,
                         input logic [4:0] rd, input logic fl, input logic rdy);
        bit  acc;
        bit  drn;
        op_t op;
        i_valid = v; i_funct3 = f3; i_funct7_5 = f7; i_use_imm = ui;
        i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_rd = rd; i_flush = fl; i_ready = rdy;
        acc = v && rdy_en && (q.size() < 2);
        drn = (q.size() > 0) && rdy;
        op  = ref_op(f3, f7, ui ? imm : rs2[4:0], rs1, rd);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(op);
        end
        rdy_en = 1'b1;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, rdy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; i_valid = 0; i_funct3 = 0; i_funct7_5 = 0; i_use_imm = 0;
        i_rs1 = 0; i_rs2 = 0; i_imm = 0; i_rd = 0; i_flush = 0; i_ready = 0;
        rdy_en = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_ready", 32'(o_ready), 32'h0);
        check("rst_result", o_result, 32'h0);
        check("rst_rd", 32'(o_rd), 32'h0);
        check("rst_illegal", 32'(o_illegal), 32'h0);
        rst = 1'b0;
        check_outputs();
        idle(1'b1);

        // SLL by rs2 amount 31
        cycle(1, 3'b001, 0, 0, 32'h1, 32'h0000001F, 5'd0, 5'd3, 0, 1);
        check("sll31", o_result, 32'h80000000);
        // SRAI / SRLI / shamt 0, back to back
        cycle(1, 3'b101, 1, 1, 32'h80000000, 32'hFFFFFFE0, 5'd4, 5'd4, 0, 1);
        check("srai4", o_result, 32'hF8000000);
        cycle(1, 3'b101, 0, 1, 32'h80000000, 32'h0, 5'd4, 5'd5, 0, 1);
        check("srli4", o_result, 32'h08000000);
        cycle(1, 3'b101, 1, 1, 32'h80000000, 32'h0, 5'd0, 5'd6, 0, 1);
        check("srai0", o_result, 32'h80000000);
        cycle(1, 3'b101, 1, 0, 32'h80000001, 32'hABCDE01F, 5'd0, 5'd7, 0, 1);
        check("sra31_neg", o_result, 32'hFFFFFFFF);
        idle(1'b1);

        // Three ops against a stalled consumer
        cycle(1, 3'b001, 0, 1, 32'h1, 32'h0, 5'd1, 5'd8, 0, 0);
        cycle(1, 3'b001, 0, 1, 32'h1, 32'h0, 5'd2, 5'd9, 0, 0);
        check("full_ready", 32'(o_ready), 32'h0);
        cycle(1, 3'b001, 0, 1, 32'h1, 32'h0, 5'd3, 5'd10, 0, 0);
        check("stall_hold", o_result, 32'h2);
        idle(1'b1);
        check("drain2", o_result, 32'h4);
        idle(1'b1);
        check("drained", 32'(o_valid), 32'h0);

        // Unsupported funct3, and SLL with funct7 bit set
        cycle(1, 3'b000, 0, 0, 32'h12345678, 32'h3, 5'd0, 5'd11, 0, 1);
        check("illegal_flag", 32'(o_illegal), 32'h1);
        check("illegal_res", o_result, 32'h0);
        cycle(1, 3'b001, 1, 0, 32'h12345678, 32'h3, 5'd0, 5'd12, 0, 1);
        check("sll_f7_illegal", 32'(o_illegal), 32'h1);
        idle(1'b1);

        // Flush while full with a simultaneous new op
        cycle(1, 3'b001, 0, 1, 32'h5, 32'h0, 5'd1, 5'd13, 0, 0);
        cycle(1, 3'b001, 0, 1, 32'h5, 32'h0, 5'd2, 5'd14, 0, 0);
        cycle(1, 3'b001, 0, 1, 32'h5, 32'h0, 5'd3, 5'd15, 1, 0);
        check("flush_valid", 32'(o_valid), 32'h0);
        check("flush_ready", 32'(o_ready), 32'h1);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset between edges while holding one op
        cycle(1, 3'b101, 0, 1, 32'hF0F0F0F0, 32'h0, 5'd4, 5'd16, 0, 0);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 32'(o_valid), 32'h0);
        check("arst_ready", 32'(o_ready), 32'h0);
        check("arst_result", o_result, 32'h0);
        q.delete();
        rdy_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("arst_rel_ready", 32'(o_ready), 32'h0);
        idle(1'b1);
        check("arst_post_ready", 32'(o_ready), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [2:0]  f3;
            logic [4:0]  imm;
            logic [31:0] rs2;
            int          sel;
            sel = $urandom_range(0, 7);
            f3  = (sel < 3) ? 3'b001 : (sel < 6) ? 3'b101 : 3'($urandom);
            imm = 5'($urandom);
            rs2 = $urandom;
            if ($urandom_range(0, 5) == 0) imm = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
            if ($urandom_range(0, 5) == 0) rs2[4:0] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
            cycle($urandom_range(0, 3) != 0, f3, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  1'($urandom), $urandom, rs2, imm, 5'($urandom),
                  $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
